// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART hex framer:
//   - ASCII constants used when rendering bytes as hex text
//   - framer FSM encoding (3-bit top state, 2-bit handshake sub-state)
//   - nibble_to_ascii(): 4-bit value -> uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   // Top-level framer states. HI..LF are the character states; each one
   // runs the transmitter handshake below before moving on.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_LATCH = 3'd2,
      ST_HI    = 3'd3,
      ST_LO    = 3'd4,
      ST_SEP   = 3'd5,
      ST_CR    = 3'd6,
      ST_LF    = 3'd7
   } state_t;

   // Per-character handshake with the transmitter.
   typedef enum logic [1:0] {
      HS_CHK  = 2'd0,
      HS_ACT  = 2'd1,
      HS_DONE = 2'd2
   } hs_t;

   // Map one nibble onto its uppercase hex character.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return ASCII_0 + {4'h0, nib};
      end
      return ASCII_A + {4'h0, nib - 4'd10};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered read data (one-cycle latency).
//   Ports:
//     clock    - rising-edge clock
//     reset_n  - synchronous active-low reset
//     wr_en    - write request; ignored while full
//     wr_data  - write data (WIDTH bits)
//     rd_en    - read request; ignored while empty
//     rd_data  - registered read data, valid the cycle after a read
//     full     - DEPTH entries stored
//     empty    - no entries stored
//     count    - number of entries stored, log2(DEPTH)+1 bits
//   DEPTH must be a power of two so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2048
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Full/empty come from the registered count, so a write at full is
   // refused even if a read happens on the same edge.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Storage array is left unreset; only the pointers define its contents.
   always_ff @(posedge clock) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered read port.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= mem[rd_ptr];
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_hex_framer.sv
// ---------------------------------------------------------------------------
// uart_hex_framer
//   Buffers a fast byte stream in a FIFO and renders each byte as two
//   uppercase hex characters plus a separator (space, or CR LF at end of
//   frame / end of line), metering characters into a UART transmitter via
//   its DV/Active/Done handshake. Input is never stalled; bytes arriving
//   while the FIFO is full are dropped and counted.
//   Ports:
//     i_Clock       - system clock, rising edge
//     i_Reset_n     - synchronous active-low reset
//     i_Data_DV     - input byte valid (one per cycle, no backpressure)
//     i_Data_Byte   - input byte
//     i_Data_Last   - with i_Data_DV: last byte of its frame
//     i_Clear_Ovf   - pulse: clear o_Overflow and o_Drop_Count
//     o_TX_DV       - one-cycle strobe to the transmitter
//     o_TX_Byte     - ASCII character, stable from strobe to next strobe
//     i_TX_Active   - transmitter shifting
//     i_TX_Done     - transmitter finished (two cycles per character)
//     o_Busy        - FIFO non-empty or FSM not idle
//     o_Overflow    - sticky: a byte was dropped
//     o_Drop_Count  - dropped byte count, saturating
// ---------------------------------------------------------------------------
module uart_hex_framer
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH     = 2048,
   parameter int BYTES_PER_LINE = 16
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Data_DV,
   input  logic [7:0]  i_Data_Byte,
   input  logic        i_Data_Last,
   input  logic        i_Clear_Ovf,
   output logic        o_TX_DV,
   output logic [7:0]  o_TX_Byte,
   input  logic        i_TX_Active,
   input  logic        i_TX_Done,
   output logic        o_Busy,
   output logic        o_Overflow,
   output logic [15:0] o_Drop_Count
);

   localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] LINE_LAST = 8'(BYTES_PER_LINE - 1);

   state_t           state;
   state_t           next_state;
   hs_t              hs;
   hs_t              next_hs;

   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [8:0]       fifo_rd_data;
   logic             fifo_wr;
   logic             fifo_rd;
   logic             drop;

   logic [7:0]       cur_byte;
   logic             cur_last;
   logic [7:0]       line_count;
   logic [7:0]       tx_byte_q;
   logic [7:0]       char_now;
   logic             tx_dv;
   logic             eol;
   logic             line_clr;
   logic             line_inc;

   assign fifo_wr = i_Data_DV && !fifo_full;
   assign drop    = i_Data_DV && fifo_full;

   sync_fifo #(
      .WIDTH (9),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (i_Clock),
      .reset_n (i_Reset_n),
      .wr_en   (fifo_wr),
      .wr_data ({i_Data_Last, i_Data_Byte}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // A byte closes its line when it ends a frame or fills the line.
   assign eol = cur_last || (line_count == LINE_LAST);

   // The strobe is combinational so the first character leaves three cycles
   // after the first write; the byte output switches to the new character on
   // the strobe cycle itself and is then held in tx_byte_q.
   assign o_TX_DV   = tx_dv;
   assign o_TX_Byte = tx_dv ? char_now : tx_byte_q;
   assign o_Busy    = (fifo_count != '0) || (state != ST_IDLE);

   // Next-state logic for the framer and its per-character handshake.
   // CHK only strobes once Active and Done are both low, which both absorbs
   // the second Done cycle of the previous character and waits out a
   // transmitter that kept shifting through a reset of this block.
   always_comb begin
      next_state = state;
      next_hs    = hs;
      tx_dv      = 1'b0;
      fifo_rd    = 1'b0;
      line_clr   = 1'b0;
      line_inc   = 1'b0;
      char_now   = 8'h00;

      case (state)
         ST_HI:   char_now = nibble_to_ascii(cur_byte[7:4]);
         ST_LO:   char_now = nibble_to_ascii(cur_byte[3:0]);
         ST_SEP:  char_now = ASCII_SP;
         ST_CR:   char_now = ASCII_CR;
         ST_LF:   char_now = ASCII_LF;
         default: char_now = 8'h00;
      endcase

      case (state)
         ST_IDLE: begin
            next_hs = HS_CHK;
            if (fifo_count != '0) begin
               next_state = ST_POP;
            end
         end
         ST_POP: begin
            fifo_rd    = !fifo_empty;
            next_state = ST_LATCH;
         end
         ST_LATCH: begin
            next_hs    = HS_CHK;
            next_state = ST_HI;
         end
         default: begin
            case (hs)
               HS_CHK: begin
                  if (!i_TX_Active && !i_TX_Done) begin
                     tx_dv   = 1'b1;
                     next_hs = HS_ACT;
                  end
               end
               HS_ACT: begin
                  if (i_TX_Active) begin
                     next_hs = HS_DONE;
                  end
               end
               HS_DONE: begin
                  if (i_TX_Done) begin
                     next_hs = HS_CHK;
                     case (state)
                        ST_HI: next_state = ST_LO;
                        ST_LO: begin
                           if (eol) begin
                              next_state = ST_CR;
                              line_clr   = 1'b1;
                           end else begin
                              next_state = ST_SEP;
                              line_inc   = 1'b1;
                           end
                        end
                        ST_CR:   next_state = ST_LF;
                        default: next_state = ST_IDLE;
                     endcase
                  end
               end
               default: next_hs = HS_CHK;
            endcase
         end
      endcase
   end

   // FSM registers, captured FIFO entry, held transmit byte, line counter.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state      <= ST_IDLE;
         hs         <= HS_CHK;
         cur_byte   <= 8'h00;
         cur_last   <= 1'b0;
         tx_byte_q  <= 8'h00;
         line_count <= 8'h00;
      end else begin
         state <= next_state;
         hs    <= next_hs;
         if (state == ST_LATCH) begin
            {cur_last, cur_byte} <= fifo_rd_data;
         end
         if (tx_dv) begin
            tx_byte_q <= char_now;
         end
         if (line_clr) begin
            line_count <= 8'h00;
         end else if (line_inc) begin
            line_count <= line_count + 8'd1;
         end
      end
   end

   // Overflow flag and drop counter. A drop in the same cycle as a clear
   // wins, restarting the count at one.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         o_Overflow   <= 1'b0;
         o_Drop_Count <= 16'h0000;
      end else if (drop) begin
         o_Overflow <= 1'b1;
         if (i_Clear_Ovf) begin
            o_Drop_Count <= 16'h0001;
         end else if (o_Drop_Count != 16'hFFFF) begin
            o_Drop_Count <= o_Drop_Count + 16'd1;
         end
      end else if (i_Clear_Ovf) begin
         o_Overflow   <= 1'b0;
         o_Drop_Count <= 16'h0000;
      end
   end

endmodule
